// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a pattern word and shifts it out MSB-first, repeated, counting "101" hits.
// Latency: first pattern bit appears on out one cycle after the load is accepted; one bit per clock thereafter.
// Backpressure: load_ready is high only in IDLE; loads offered while busy are ignored until the FSM returns to IDLE.
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int REP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_rep,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   data_q;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   len_m1;
    logic [REP_W-1:0]   reps_left;
    logic [1:0]         hist;

    logic [LEN_W-1:0]   eff_len;
    logic [IDX_W-1:0]   eff_len_m1;
    logic [REP_W-1:0]   eff_rep;
    logic               cur_bit;

    assign load_ready = (state == IDLE);
    assign cur_bit    = data_q[idx];

    // Normalise the requested length and repeat count: 0 or oversize length means full width, 0 repeats means one.
    always_comb begin
        eff_len = load_len;
        if ((load_len == '0) || (load_len > LEN_W'(WIDTH))) begin
            eff_len = LEN_W'(WIDTH);
        end
        eff_rep = (load_rep == '0) ? REP_W'(1) : load_rep;
    end

    assign eff_len_m1 = IDX_W'(eff_len - LEN_W'(1));

    // Transmit FSM with registered outputs; history holds the last two emitted bits for overlapping 101 detection.
    always_ff @(posedge clk) begin
        if (R) begin
            state     <= IDLE;
            data_q    <= '0;
            idx       <= '0;
            len_m1    <= '0;
            reps_left <= '0;
            hist      <= 2'b00;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (load_valid) begin
                        data_q    <= load_data;
                        len_m1    <= eff_len_m1;
                        idx       <= eff_len_m1;
                        reps_left <= eff_rep;
                        hit_cnt   <= '0;
                        hist      <= 2'b00;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    done <= 1'b0;
                    if (abort) begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out       <= cur_bit;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        hist      <= {hist[0], cur_bit};
                        // Counter saturates rather than wrapping so long streams never under-report.
                        if ((hist == 2'b10) && cur_bit && (hit_cnt != '1)) begin
                            hit_cnt <= hit_cnt + CNT_W'(1);
                        end
                        if (idx == '0) begin
                            if (reps_left > REP_W'(1)) begin
                                idx       <= len_m1;
                                reps_left <= reps_left - REP_W'(1);
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            idx <= idx - IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: loads patterns, captures the serial stream and checks bits, counts and pulses.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each comparison is an immediate assertion that counts and reports its own miscompare.
module tb_serial_pattern_tx;

    logic        clk;
    logic        R;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [4:0]  load_len;
    logic [7:0]  load_rep;
    logic        abort;
    logic        out;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [15:0] hit_cnt;

    int vectors;
    int miscompares;

    logic [63:0] bits;
    int          nbits;
    logic        done_after;
    int          done_during;

    serial_pattern_tx #(
        .WIDTH(16),
        .LEN_W(5),
        .REP_W(8),
        .CNT_W(16)
    ) dut (
        .clk        (clk),
        .R          (R),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_rep   (load_rep),
        .abort      (abort),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .hit_cnt    (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a load for one accepting edge; optionally leave load_valid asserted afterwards.
    task automatic send(input logic [15:0] d, input logic [4:0] len, input logic [7:0] rep, input logic keep);
        load_data  = d;
        load_len   = len;
        load_rep   = rep;
        load_valid = 1'b1;
        tick();
        load_valid = keep;
    endtask

    // Capture out while out_valid is high; stops on the first idle sample after the stream, bounded in cycles.
    task automatic collect(output logic [63:0] b, output int n, output logic d_after, output int d_during);
        logic fin;
        b        = '0;
        n        = 0;
        d_after  = 1'b0;
        d_during = 0;
        fin      = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            tick();
            if (out_valid) begin
                b = {b[62:0], out};
                n++;
                if (done) d_during++;
            end else if (n > 0) begin
                d_after = done;
                fin     = 1'b1;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        R           = 1'b1;
        load_valid  = 1'b0;
        load_data   = '0;
        load_len    = '0;
        load_rep    = '0;
        abort       = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out", 64'(out), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        R = 1'b0;
        tick();
        check("rst_load_ready", 64'(load_ready), 64'd1);

        // Test 1: 101, len 3, rep 1
        send(16'b101, 5'd3, 8'd1, 1'b0);
        check("t1_ready_low", 64'(load_ready), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_no_bit_yet", 64'(out_valid), 64'd0);
        collect(bits, nbits, done_after, done_during);
        check("t1_nbits", 64'(nbits), 64'd3);
        check("t1_bits", bits, 64'b101);
        check("t1_done", 64'(done_after), 64'd1);
        check("t1_hit", 64'(hit_cnt), 64'd1);
        check("t1_busy_end", 64'(busy), 64'd0);
        tick();
        check("t1_done_one_cycle", 64'(done), 64'd0);

        // Test 2: 101 repeated 3 times back-to-back
        send(16'b101, 5'd3, 8'd3, 1'b0);
        collect(bits, nbits, done_after, done_during);
        check("t2_nbits", 64'(nbits), 64'd9);
        check("t2_bits", bits, 64'b101101101);
        check("t2_hit", 64'(hit_cnt), 64'd3);
        check("t2_done", 64'(done_after), 64'd1);
        check("t2_no_early_done", 64'(done_during), 64'd0);

        // Test 3: len 0 means full width
        send(16'hAAAA, 5'd0, 8'd1, 1'b0);
        collect(bits, nbits, done_after, done_during);
        check("t3_nbits", 64'(nbits), 64'd16);
        check("t3_bits", bits, 64'hAAAA);
        check("t3_hit", 64'(hit_cnt), 64'd7);
        tick();
        tick();
        tick();
        check("t3_hit_holds", 64'(hit_cnt), 64'd7);

        // Test 4: 10101 rep 2, abort after sixth bit
        send(16'b10101, 5'd5, 8'd2, 1'b0);
        bits  = '0;
        nbits = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) begin
                bits = {bits[62:0], out};
                nbits++;
            end
        end
        check("t4_nbits", 64'(nbits), 64'd6);
        check("t4_bits", bits, 64'b101011);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_valid", 64'(out_valid), 64'd0);
        check("t4_abort_out", 64'(out), 64'd0);
        check("t4_abort_busy", 64'(busy), 64'd0);
        check("t4_abort_ready", 64'(load_ready), 64'd1);
        check("t4_abort_hit", 64'(hit_cnt), 64'd2);
        check("t4_abort_no_done", 64'(done), 64'd0);
        tick();
        check("t4_abort_no_done_late", 64'(done), 64'd0);

        // Test 5: synchronous reset during SHIFT
        send(16'b101, 5'd3, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_mid_hit", 64'(hit_cnt), 64'd1);
        R = 1'b1;
        tick();
        R = 1'b0;
        check("t5_out", 64'(out), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_hit", 64'(hit_cnt), 64'd0);
        check("t5_ready", 64'(load_ready), 64'd1);
        tick();
        check("t5_quiet", 64'(out_valid), 64'd0);

        // Test 6: load while busy is ignored, then accepted once back in IDLE
        send(16'b101, 5'd3, 8'd1, 1'b1);
        load_data = 16'b111;
        load_len  = 5'd3;
        load_rep  = 8'd1;
        collect(bits, nbits, done_after, done_during);
        check("t6_nbits", 64'(nbits), 64'd3);
        check("t6_bits", bits, 64'b101);
        check("t6_hit", 64'(hit_cnt), 64'd1);
        check("t6_ready_after", 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
        check("t6_accepted", 64'(busy), 64'd1);
        collect(bits, nbits, done_after, done_during);
        check("t6b_nbits", 64'(nbits), 64'd3);
        check("t6b_bits", bits, 64'b111);
        check("t6b_hit_cleared", 64'(hit_cnt), 64'd0);

        // len 1, rep 0 -> single bit
        send(16'h0001, 5'd1, 8'd0, 1'b0);
        collect(bits, nbits, done_after, done_during);
        check("len1_nbits", 64'(nbits), 64'd1);
        check("len1_bit", bits, 64'b1);
        check("len1_done", 64'(done_after), 64'd1);

        // len 2 of ...01, rep 3 -> 010101, hits span repeat boundaries
        send(16'b0101, 5'd2, 8'd3, 1'b0);
        collect(bits, nbits, done_after, done_during);
        check("len2_nbits", 64'(nbits), 64'd6);
        check("len2_bits", bits, 64'b010101);
        check("len2_hit", 64'(hit_cnt), 64'd2);

        // Oversize length clamps to full width
        send(16'h8001, 5'd20, 8'd1, 1'b0);
        collect(bits, nbits, done_after, done_during);
        check("big_nbits", 64'(nbits), 64'd16);
        check("big_bits", bits, 64'h8001);
        check("big_hit", 64'(hit_cnt), 64'd0);

        // abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_ready", 64'(load_ready), 64'd1);
        check("idle_abort_hit", 64'(hit_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
